// File: rtl/fp16_mul_result_stage.sv
// fp16_mul_result_stage: FIFO-buffered FP16 multiplier result stage with sticky exception flags and a saturating op counter
module fp16_mul_result_stage #(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_result,
  input  logic [3:0]         in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_result,
  output logic [3:0]         out_flags,
  output logic               out_is_nan,
  input  logic               clear_sticky,
  output logic [2:0]         sticky_flags,
  output logic [COUNT_W-1:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  logic [19:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               push, pop, in_nan;
  logic [19:0]        head;
  logic [2:0]         sticky_base;
  logic [COUNT_W-1:0] cnt_base;
  assign in_ready   = count != (AW+1)'(DEPTH);
  assign out_valid  = count != '0;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head       = mem[rd_ptr];
  // Outputs read as zero when empty so an async reset clears them without an edge
  assign out_result = out_valid ? head[19:4] : '0;
  assign out_flags  = out_valid ? head[3:0] : '0;
  assign out_is_nan = out_valid && out_result[14:10] == 5'h1F && out_result[9:0] != '0;
  assign in_nan     = in_result[14:10] == 5'h1F && in_result[9:0] != '0;
  assign sticky_base = clear_sticky ? '0 : sticky_flags;
  assign cnt_base    = clear_sticky ? '0 : op_count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_result, in_flags};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      wr_ptr       <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count        <= count + (AW+1)'(push) - (AW+1)'(pop);
      sticky_flags <= push ? sticky_base | {in_nan, in_flags[1:0]} : sticky_base;
      op_count     <= (push && cnt_base != '1) ? cnt_base + COUNT_W'(1) : cnt_base;
    end
endmodule
